// File: rtl/mips_trace_buffer_pkg.sv
// Shared encodings for the commit-trace unit: FSM states and capture modes.
package mips_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } trace_state_e;

  localparam logic MODE_STOP = 1'b0;
  localparam logic MODE_WRAP = 1'b1;

endpackage

// File: rtl/mips_trace_buffer_ring.sv
// Ring buffer of trace entries: push/pop/overwrite with a saturating count.
// A push while full advances the read pointer too, which drops the oldest
// entry (overwrite) or, if a pop fires in the same cycle, replaces the popped one.
module trace_ring #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          empty, full, pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop     = pop_i && !empty;
  assign full_o  = full;
  assign count_o = count_q;
  assign rdata_o = empty ? '0 : mem_q[rptr_q];

  // Next occupancy: grows on a lone push into free space, shrinks on a lone pop.
  always_comb begin
    count_d = count_q;
    if (push_i && !pop && !full)
      count_d = count_q + CW'(1);
    else if (pop && !push_i)
      count_d = count_q - CW'(1);
  end

  // Pointer and count registers, cleared on reset or arm.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (clr_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i)
        wptr_q <= wptr_q + AW'(1);
      if (pop || (push_i && full))
        rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Entry storage; contents of empty slots are never observed.
  always_ff @(posedge clk) begin
    if (push_i && !clr_i)
      mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mips_trace_buffer.sv
// Commit-trace capture: arm/trigger FSM, hang watchdog and sticky flags
// around a (PC, IR) ring buffer drained through a valid/ready port.
module mips_trace_buffer
  import mips_trace_pkg::*;
#(
  parameter int unsigned PC_W       = 32,
  parameter int unsigned IR_W       = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned HANG_LIMIT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic                     mode,
  input  logic                     trig_en,
  input  logic [PC_W-1:0]          trig_pc,
  input  logic                     stop,
  input  logic                     commit,
  input  logic [PC_W-1:0]          pc,
  input  logic [IR_W-1:0]          ir,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [PC_W-1:0]          rd_pc,
  output logic [IR_W-1:0]          rd_ir,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     hang,
  output logic [1:0]               state
);

  localparam int unsigned HW = $clog2(HANG_LIMIT + 1);

  trace_state_e    state_q;
  logic            mode_q, trig_en_q;
  logic [PC_W-1:0] trig_pc_q;
  logic [HW-1:0]   hcnt_q;
  logic            overflow_q, hang_q;

  logic            full, trig_hit, push, pop_fire;

  assign trig_hit = !trig_en_q || (pc == trig_pc_q);
  assign rd_valid = (count != '0);
  assign pop_fire = rd_ready && rd_valid;
  assign overflow = overflow_q;
  assign hang     = hang_q;
  assign state    = state_q;

  // Push decision: arm and stop both suppress a same-cycle commit.
  always_comb begin
    push = 1'b0;
    if (!arm && !stop && commit) begin
      case (state_q)
        ST_ARMED:   push = trig_hit;
        ST_CAPTURE: push = !full || (mode_q == MODE_WRAP);
        default:    push = 1'b0;
      endcase
    end
  end

  trace_ring #(
    .DEPTH (DEPTH),
    .W     (PC_W + IR_W)
  ) u_ring (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (arm),
    .push_i  (push),
    .pop_i   (rd_ready && !arm),
    .wdata_i ({pc, ir}),
    .rdata_o ({rd_pc, rd_ir}),
    .count_o (count),
    .full_o  (full)
  );

  // Capture FSM with trigger latch, hang watchdog and sticky flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_STOP;
      trig_en_q  <= 1'b0;
      trig_pc_q  <= '0;
      hcnt_q     <= '0;
      overflow_q <= 1'b0;
      hang_q     <= 1'b0;
    end else if (arm) begin
      state_q    <= ST_ARMED;
      mode_q     <= mode;
      trig_en_q  <= trig_en;
      trig_pc_q  <= trig_pc;
      hcnt_q     <= '0;
      overflow_q <= 1'b0;
      hang_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (stop)
            state_q <= ST_DONE;
          else if (commit && trig_hit) begin
            state_q <= ST_CAPTURE;
            hcnt_q  <= '0;
          end
        end
        ST_CAPTURE: begin
          if (stop)
            state_q <= ST_DONE;
          else if (commit) begin
            hcnt_q <= '0;
            if (full) begin
              if (mode_q == MODE_STOP) begin
                overflow_q <= 1'b1;
                state_q    <= ST_DONE;
              end else if (!pop_fire)
                overflow_q <= 1'b1;
            end
          end else if (hcnt_q == HW'(HANG_LIMIT - 1)) begin
            hang_q  <= 1'b1;
            state_q <= ST_DONE;
          end else
            hcnt_q <= hcnt_q + HW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
